// File: rtl/conv_window_mac_3d.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : conv_window_mac_3d                                               |
// | Purpose : 5x5 window multiply-accumulate behind the 3-D conv address       |
// |           generator. Each beat multiplies 25 pixels by 25 weights, reduces |
// |           the products in a 4-stage pipeline and accumulates the result    |
// |           per anchor across depth slices in an internal partial-sum        |
// |           buffer. One result per anchor leaves on the last depth slice.    |
// | Ports   : clk, rst_n (async, active low)                                   |
// |           enable      0 flushes the pipeline and clears the index counter  |
// |           pause       1 freezes pipeline, counter and outputs              |
// |           in_valid / in_depth / in_pixels / in_weights : window beat       |
// |           out_valid / out_result / out_index : finished anchor result      |
// |           frame_done  pulses with the result for the last anchor           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module conv_window_mac_3d #(
  parameter int PIX_WIDTH              = 8,
  parameter int ACC_WIDTH              = 32,
  parameter int ANCHOR_WIDTH_BOUNDARY  = 31,
  parameter int ANCHOR_HEIGHT_BOUNDARY = 31,
  parameter int DATA_DEPTH             = 1,
  parameter int PORT_NUM               = 25,
  parameter int IDX_WIDTH              = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          pause,
  input  logic                          in_valid,
  input  logic [7:0]                    in_depth,
  input  logic [PORT_NUM*PIX_WIDTH-1:0] in_pixels,
  input  logic [PORT_NUM*PIX_WIDTH-1:0] in_weights,
  output logic                          out_valid,
  output logic [ACC_WIDTH-1:0]          out_result,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic                          frame_done
);

  localparam int ANCHORS = ANCHOR_WIDTH_BOUNDARY * ANCHOR_HEIGHT_BOUNDARY;
  localparam int AW      = (ANCHORS > 1) ? $clog2(ANCHORS) : 1;
  localparam int PROD_W  = 2 * PIX_WIDTH;
  localparam int ROW_W   = PROD_W + 3;   // room for 5 products
  localparam int SUM_W   = PROD_W + 5;   // room for 25 products
  localparam logic [7:0]           LAST_DEPTH = 8'(DATA_DEPTH - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(ANCHORS - 1);

  // The buffer read for an anchor must land after the previous write to the
  // same anchor; with at least 5 anchors the two never overlap in the pipe.
  if (ANCHORS < 5 || PORT_NUM != 25 || DATA_DEPTH < 1 || DATA_DEPTH > 256 ||
      ACC_WIDTH < SUM_W || AW > IDX_WIDTH) begin : g_param_check
    $error("conv_window_mac_3d: illegal parameter combination");
  end

  logic                               advance;
  logic [IDX_WIDTH-1:0]               cnt_q, cnt_d;
  logic                               s1_valid_q, s1_valid_d;
  logic [PORT_NUM-1:0][PROD_W-1:0]    s1_prod_q, s1_prod_d;
  logic [7:0]                         s1_depth_q, s1_depth_d;
  logic [IDX_WIDTH-1:0]               s1_idx_q, s1_idx_d;
  logic                               s2_valid_q, s2_valid_d;
  logic [4:0][ROW_W-1:0]              s2_row_q, s2_row_d;
  logic [7:0]                         s2_depth_q, s2_depth_d;
  logic [IDX_WIDTH-1:0]               s2_idx_q, s2_idx_d;
  logic                               s3_valid_q, s3_valid_d;
  logic [ACC_WIDTH-1:0]               s3_sum_q, s3_sum_d;
  logic [7:0]                         s3_depth_q, s3_depth_d;
  logic [IDX_WIDTH-1:0]               s3_idx_q, s3_idx_d;
  logic [ACC_WIDTH-1:0]               mem_rdata_q;
  logic [ACC_WIDTH-1:0]               acc;
  logic                               emit;
  logic                               out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]               out_result_q, out_result_d;
  logic [IDX_WIDTH-1:0]               out_index_q, out_index_d;
  logic                               frame_done_q, frame_done_d;
  logic [ACC_WIDTH-1:0]               psum_mem [ANCHORS];

  assign advance = enable && !pause;
  // Depth 0 starts a fresh sum, so stale buffer contents never leak in.
  assign acc     = (s3_depth_q == 8'd0) ? s3_sum_q : (mem_rdata_q + s3_sum_q);
  assign emit    = s3_valid_q && (s3_depth_q == LAST_DEPTH);

  always_comb begin
    logic signed [PROD_W-1:0] px;
    logic signed [PROD_W-1:0] wt;
    logic signed [ROW_W-1:0]  row;
    logic signed [SUM_W-1:0]  total;
    px           = '0;
    wt           = '0;
    row          = '0;
    total        = '0;
    cnt_d        = cnt_q;
    s1_valid_d   = s1_valid_q;
    s1_prod_d    = s1_prod_q;
    s1_depth_d   = s1_depth_q;
    s1_idx_d     = s1_idx_q;
    s2_valid_d   = s2_valid_q;
    s2_row_d     = s2_row_q;
    s2_depth_d   = s2_depth_q;
    s2_idx_d     = s2_idx_q;
    s3_valid_d   = s3_valid_q;
    s3_sum_d     = s3_sum_q;
    s3_depth_d   = s3_depth_q;
    s3_idx_d     = s3_idx_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_index_d  = out_index_q;
    frame_done_d = frame_done_q;

    if (!enable) begin
      // Flush wins over pause: drop everything in flight.
      cnt_d        = '0;
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      s3_valid_d   = 1'b0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end else if (!pause) begin
      if (in_valid) begin
        cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_WIDTH'(1);
      end

      s1_valid_d = in_valid;
      s1_depth_d = in_depth;
      s1_idx_d   = cnt_q;
      for (int i = 0; i < PORT_NUM; i++) begin
        px = PROD_W'($signed(in_pixels[i*PIX_WIDTH +: PIX_WIDTH]));
        wt = PROD_W'($signed(in_weights[i*PIX_WIDTH +: PIX_WIDTH]));
        s1_prod_d[i] = px * wt;
      end

      s2_valid_d = s1_valid_q;
      s2_depth_d = s1_depth_q;
      s2_idx_d   = s1_idx_q;
      for (int r = 0; r < 5; r++) begin
        row = '0;
        for (int c = 0; c < 5; c++) begin
          row = row + ROW_W'($signed(s1_prod_q[r*5+c]));
        end
        s2_row_d[r] = row;
      end

      s3_valid_d = s2_valid_q;
      s3_depth_d = s2_depth_q;
      s3_idx_d   = s2_idx_q;
      for (int r = 0; r < 5; r++) begin
        total = total + SUM_W'($signed(s2_row_q[r]));
      end
      s3_sum_d = ACC_WIDTH'(total);

      out_valid_d  = emit;
      frame_done_d = emit && (s3_idx_q == LAST_IDX);
      if (emit) begin
        out_result_d = acc;
        out_index_d  = s3_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_prod_q    <= '0;
      s1_depth_q   <= '0;
      s1_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_row_q     <= '0;
      s2_depth_q   <= '0;
      s2_idx_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_sum_q     <= '0;
      s3_depth_q   <= '0;
      s3_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_prod_q    <= s1_prod_d;
      s1_depth_q   <= s1_depth_d;
      s1_idx_q     <= s1_idx_d;
      s2_valid_q   <= s2_valid_d;
      s2_row_q     <= s2_row_d;
      s2_depth_q   <= s2_depth_d;
      s2_idx_q     <= s2_idx_d;
      s3_valid_q   <= s3_valid_d;
      s3_sum_q     <= s3_sum_d;
      s3_depth_q   <= s3_depth_d;
      s3_idx_q     <= s3_idx_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_index_q  <= out_index_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Partial-sum buffer: one write (S4) and one registered read (issued with
  // S3) per cycle. Left uninitialised; depth-0 beats overwrite entries.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (s3_valid_q) begin
        psum_mem[s3_idx_q[AW-1:0]] <= acc;
      end
      mem_rdata_q <= psum_mem[s2_idx_q[AW-1:0]];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_index  = out_index_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
